// File: rtl/dmem_pkg.sv
// Shared encodings and pure helpers for the data memory controller:
// access sizes, FSM states, byte-enable / store-lane / alignment functions.
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Size 11 is reserved and always treated as illegal.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = off[0];
      SZ_W:    misaligned = (off != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] be_of(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    be_of = 4'b0001 << off;
      SZ_H:    be_of = 4'b0011 << off;
      SZ_W:    be_of = 4'b1111;
      default: be_of = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SZ_B:    store_lanes = {4{data[7:0]}};
      SZ_H:    store_lanes = {2{data[15:0]}};
      default: store_lanes = data;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Combinational load extract: moves the addressed byte/half down to bit 0
// and sign- or zero-extends it; words pass straight through.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        sign,
  output logic [31:0] result
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {off, 3'b000};
    case (size)
      SZ_B:    result = {{24{sign & shifted[7]}}, shifted[7:0]};
      SZ_H:    result = {{16{sign & shifted[15]}}, shifted[15:0]};
      SZ_W:    result = rdata;
      default: result = 32'h0;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// CPU-to-data-memory sequencer with req/ack handshake and error screening.
// Define DMEM_STORE_BUF_EN to post legal stores through a one-entry write buffer.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_size,
  input  logic              cpu_sign,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_err,
  output logic              cpu_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

`ifdef DMEM_STORE_BUF_EN
  localparam bit STORE_BUF = 1'b1;
`else
  localparam bit STORE_BUF = 1'b0;
`endif

  state_t            state, state_next;
  logic [1:0]        size_reg, off_reg;
  logic              sign_reg, posted_reg;
  logic              accept, err_now, post_now;
  logic [31:0]       load_result;

  logic              mem_req_next, mem_we_next, cpu_done_next, cpu_err_next, posted_next;
  logic [ADDR_W-1:0] mem_addr_next;
  logic [3:0]        mem_be_next;
  logic [31:0]       mem_wdata_next, cpu_rdata_next;

  dmem_load_align u_align (
    .rdata  (mem_rdata),
    .size   (size_reg),
    .off    (off_reg),
    .sign   (sign_reg),
    .result (load_result)
  );

  assign accept    = (state == ST_IDLE) && cpu_req;
  assign err_now   = misaligned(cpu_size, cpu_addr[1:0]);
  assign post_now  = STORE_BUF && accept && !err_now && cpu_we;
  assign cpu_stall = cpu_req & ~cpu_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      size_reg   <= 2'b00;
      off_reg    <= 2'b00;
      sign_reg   <= 1'b0;
      posted_reg <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= 4'h0;
      mem_wdata  <= 32'h0;
      cpu_rdata  <= 32'h0;
      cpu_done   <= 1'b0;
      cpu_err    <= 1'b0;
    end else begin
      state      <= state_next;
      posted_reg <= posted_next;
      if (accept) begin
        size_reg <= cpu_size;
        off_reg  <= cpu_addr[1:0];
        sign_reg <= cpu_sign;
      end
      mem_req    <= mem_req_next;
      mem_we     <= mem_we_next;
      mem_addr   <= mem_addr_next;
      mem_be     <= mem_be_next;
      mem_wdata  <= mem_wdata_next;
      cpu_rdata  <= cpu_rdata_next;
      cpu_done   <= cpu_done_next;
      cpu_err    <= cpu_err_next;
    end
  end

  // A drained posted store returns to IDLE without a second completion.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (cpu_req) state_next = err_now ? ST_RESP : ST_WAIT;
      ST_WAIT: if (mem_ack) state_next = posted_reg ? ST_IDLE : ST_RESP;
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_req_next   = (state_next == ST_WAIT);
    mem_we_next    = 1'b0;
    mem_addr_next  = '0;
    mem_be_next    = 4'h0;
    mem_wdata_next = 32'h0;
    if (accept && !err_now) begin
      mem_we_next    = cpu_we;
      mem_addr_next  = {cpu_addr[ADDR_W-1:2], 2'b00};
      mem_be_next    = be_of(cpu_size, cpu_addr[1:0]);
      mem_wdata_next = cpu_we ? store_lanes(cpu_size, cpu_wdata) : 32'h0;
    end else if (state_next == ST_WAIT) begin
      mem_we_next    = mem_we;
      mem_addr_next  = mem_addr;
      mem_be_next    = mem_be;
      mem_wdata_next = mem_wdata;
    end
    cpu_done_next  = (state_next == ST_RESP) || post_now;
    cpu_err_next   = accept && err_now;
    cpu_rdata_next = (state == ST_WAIT && mem_ack && !posted_reg) ? load_result : 32'h0;
    posted_next    = accept ? post_now : ((state_next == ST_WAIT) ? posted_reg : 1'b0);
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed self-checking bench for data_mem_ctrl; checks are sampled on the
// falling edge, between the rising edges the design acts on.
module tb_data_mem_ctrl;
  import dmem_pkg::*;

`ifdef DMEM_STORE_BUF_EN
  localparam bit BUF = 1'b1;
`else
  localparam bit BUF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_sign;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_done, cpu_err, cpu_stall;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_sign(cpu_sign),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_stall(cpu_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_req(input logic we, input logic [1:0] size, input logic sign,
                         input logic [31:0] addr, input logic [31:0] wdata);
    cpu_req = 1'b1; cpu_we = we; cpu_size = size; cpu_sign = sign;
    cpu_addr = addr; cpu_wdata = wdata;
  endtask

  task automatic do_store(input string tag, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_addr,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    set_req(1'b1, size, 1'b0, addr, wdata);
    step();
    chk({tag, " mem_req"}, mem_req, 1);
    chk({tag, " mem_we"}, mem_we, 1);
    chk({tag, " mem_addr"}, mem_addr, exp_addr);
    chk({tag, " mem_be"}, mem_be, exp_be);
    chk({tag, " mem_wdata"}, mem_wdata, exp_wdata);
    chk({tag, " done_c1"}, cpu_done, BUF);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk({tag, " done_c2"}, cpu_done, !BUF);
    chk({tag, " mem_req_c2"}, mem_req, 0);
    cpu_req = 1'b0;
    step();
    chk({tag, " done_c3"}, cpu_done, 0);
    $display("store %s addr=0x%08h be=%b wdata=0x%08h", tag, mem_addr, exp_be, exp_wdata);
  endtask

  task automatic do_load(input string tag, input logic [1:0] size, input logic sign,
                         input logic [31:0] addr, input logic [31:0] rdata,
                         input logic [31:0] exp_addr, input logic [3:0] exp_be,
                         input logic [31:0] exp_res);
    set_req(1'b0, size, sign, addr, 32'h0);
    step();
    chk({tag, " mem_req"}, mem_req, 1);
    chk({tag, " mem_we"}, mem_we, 0);
    chk({tag, " mem_addr"}, mem_addr, exp_addr);
    chk({tag, " mem_be"}, mem_be, exp_be);
    chk({tag, " mem_wdata"}, mem_wdata, 0);
    chk({tag, " stall"}, cpu_stall, 1);
    mem_ack = 1'b1; mem_rdata = rdata;
    step();
    mem_ack = 1'b0;
    chk({tag, " done"}, cpu_done, 1);
    chk({tag, " err"}, cpu_err, 0);
    chk({tag, " rdata"}, cpu_rdata, exp_res);
    cpu_req = 1'b0;
    step();
    chk({tag, " done_after"}, cpu_done, 0);
    chk({tag, " rdata_after"}, cpu_rdata, 0);
    $display("load %s addr=0x%08h mem=0x%08h result=0x%08h", tag, addr, rdata, exp_res);
  endtask

  task automatic do_err(input string tag, input logic we, input logic [1:0] size,
                        input logic [31:0] addr);
    set_req(we, size, 1'b1, addr, 32'hFFFF_FFFF);
    step();
    chk({tag, " done"}, cpu_done, 1);
    chk({tag, " err"}, cpu_err, 1);
    chk({tag, " mem_req"}, mem_req, 0);
    chk({tag, " rdata"}, cpu_rdata, 0);
    cpu_req = 1'b0;
    step();
    chk({tag, " done_after"}, cpu_done, 0);
    chk({tag, " err_after"}, cpu_err, 0);
    chk({tag, " mem_req_after"}, mem_req, 0);
    $display("error %s addr=0x%08h size=%b", tag, addr, size);
  endtask

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_size = SZ_B; cpu_sign = 1'b0;
    cpu_addr = 32'h0; cpu_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    step(); step();
    chk("rst mem_req", mem_req, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_be", mem_be, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst cpu_done", cpu_done, 0);
    chk("rst cpu_rdata", cpu_rdata, 0);
    chk("rst cpu_stall", cpu_stall, 0);
    rst = 1'b0;
    step();
    $display("reset released");

    do_store("sb13", SZ_B, 32'h13, 32'h0000_FFFF, 32'h10, 4'b1000, 32'hFFFF_FFFF);
    do_store("sh06", SZ_H, 32'h06, 32'h1234_ABCD, 32'h04, 4'b1100, 32'hABCD_ABCD);
    do_store("sw24", SZ_W, 32'h24, 32'hDEAD_BEEF, 32'h24, 4'b1111, 32'hDEAD_BEEF);

    do_load("lh02",  SZ_H, 1'b1, 32'h002, 32'h8001_1234, 32'h000, 4'b1100, 32'hFFFF_8001);
    do_load("lhu02", SZ_H, 1'b0, 32'h002, 32'h8001_1234, 32'h000, 4'b1100, 32'h0000_8001);
    do_load("lh08",  SZ_H, 1'b1, 32'h008, 32'h8001_1234, 32'h008, 4'b0011, 32'h0000_1234);
    do_load("lb101", SZ_B, 1'b1, 32'h101, 32'h0000_80FF, 32'h100, 4'b0010, 32'hFFFF_FF80);
    do_load("lbu03", SZ_B, 1'b0, 32'h003, 32'hAB00_0000, 32'h000, 4'b1000, 32'h0000_00AB);
    do_load("lw0c",  SZ_W, 1'b1, 32'h00C, 32'h89AB_CDEF, 32'h00C, 4'b1111, 32'h89AB_CDEF);

    do_err("lw05", 1'b0, SZ_W, 32'h5);
    do_err("sh01", 1'b1, SZ_H, 32'h1);
    do_err("ld11", 1'b0, 2'b11, 32'h0);

    // Slow memory: request must hold steady until the ack arrives.
    set_req(1'b0, SZ_W, 1'b0, 32'h40, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("slow c%0d mem_req", i), mem_req, 1);
      chk($sformatf("slow c%0d mem_addr", i), mem_addr, 32'h40);
      chk($sformatf("slow c%0d mem_be", i), mem_be, 4'b1111);
      chk($sformatf("slow c%0d stall", i), cpu_stall, 1);
      chk($sformatf("slow c%0d done", i), cpu_done, 0);
    end
    mem_ack = 1'b1; mem_rdata = 32'h5A5A_0F0F;
    step();
    mem_ack = 1'b0;
    chk("slow done", cpu_done, 1);
    chk("slow rdata", cpu_rdata, 32'h5A5A_0F0F);
    chk("slow stall", cpu_stall, 0);
    cpu_req = 1'b0;
    step();
    chk("slow done_after", cpu_done, 0);
    $display("slow load addr=0x00000040 result=0x5a5a0f0f");

    // Stray acks while idle must do nothing.
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    step(); step();
    chk("stray done", cpu_done, 0);
    chk("stray mem_req", mem_req, 0);
    chk("stray rdata", cpu_rdata, 0);
    mem_ack = 1'b0;
    $display("stray ack ignored");

    // Reset in the middle of an access.
    set_req(1'b0, SZ_W, 1'b0, 32'h8, 32'h0);
    step();
    chk("midrst mem_req_before", mem_req, 1);
    #1 rst = 1'b1;
    #1;
    chk("midrst mem_req_async", mem_req, 0);
    chk("midrst mem_be", mem_be, 0);
    chk("midrst mem_addr", mem_addr, 0);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0; cpu_req = 1'b0; rst = 1'b0;
    step();
    chk("midrst done", cpu_done, 0);
    chk("midrst mem_req", mem_req, 0);
    $display("reset during access abandoned");

`ifdef DMEM_STORE_BUF_EN
    // Posted store followed by a dependent load.
    set_req(1'b1, SZ_W, 1'b0, 32'h20, 32'hCAFE_BABE);
    step();
    chk("buf st done", cpu_done, 1);
    chk("buf st mem_req", mem_req, 1);
    chk("buf st mem_we", mem_we, 1);
    set_req(1'b0, SZ_W, 1'b0, 32'h20, 32'h0);
    step();
    chk("buf drain mem_we", mem_we, 1);
    chk("buf drain stall", cpu_stall, 1);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("buf ld held mem_req", mem_req, 0);
    chk("buf ld held stall", cpu_stall, 1);
    step();
    chk("buf ld mem_req", mem_req, 1);
    chk("buf ld mem_we", mem_we, 0);
    chk("buf ld mem_addr", mem_addr, 32'h20);
    step();
    chk("buf ld wait done", cpu_done, 0);
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_BABE;
    step();
    mem_ack = 1'b0;
    chk("buf ld done", cpu_done, 1);
    chk("buf ld rdata", cpu_rdata, 32'hCAFE_BABE);
    cpu_req = 1'b0;
    step();
    $display("posted store then load addr=0x00000020 result=0xcafebabe");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
